// File: rtl/debug_rf_reader.sv
// Debug bus initiator: walks register-file debug addresses, captures each word,
// and streams it as a 5-byte packet (header + data MSB first) over a valid/ready byte channel.
module debug_rf_reader #(
  parameter int unsigned FIRST_REG     = 0,
  parameter int unsigned LAST_REG      = 31,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        single,
  input  logic [4:0]  sel_addr,
  output logic [4:0]  rf_ra,
  input  logic [31:0] rf_rd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned IW = 3;

  if (FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
    $error("debug_rf_reader: need FIRST_REG <= LAST_REG <= 31");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("debug_rf_reader: SETTLE_CYCLES must be 1..15");
  end

  typedef enum logic [1:0] {IDLE, SETTLE, SEND, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DW-1:0] hold;
  logic          single_q;
  logic [BW-1:0] next_byte;
  logic          accept, settle_last, hs, last_byte, last_reg;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SETTLE;
      SETTLE:  if (settle_last) state_nx = SEND;
      SEND:    if (hs && last_byte) state_nx = last_reg ? DONE : SETTLE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control strobes decoded from state and counters
  always_comb begin
    accept      = 1'b0;
    settle_last = 1'b0;
    hs          = 1'b0;
    last_byte   = (idx == IW'(4));
    last_reg    = single_q || (rf_ra == AW'(LAST_REG));
    case (state)
      IDLE:    accept      = start;
      SETTLE:  settle_last = (cnt == CW'(SETTLE_CYCLES - 1));
      SEND:    hs          = tx_valid && tx_ready;
      default: ;
    endcase
  end

  // Data byte following the current one (idx 0 is the header)
  always_comb begin
    next_byte = hold[31:24];
    case (idx)
      IW'(1):  next_byte = hold[23:16];
      IW'(2):  next_byte = hold[15:8];
      IW'(3):  next_byte = hold[7:0];
      default: next_byte = hold[31:24];
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_ra    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      idx      <= '0;
      hold     <= '0;
      single_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        single_q <= single;
        rf_ra    <= single ? sel_addr : AW'(FIRST_REG);
        cnt      <= '0;
        busy     <= 1'b1;
      end
      if (state == SETTLE) begin
        cnt <= cnt + CW'(1);
        if (settle_last) begin
          hold     <= rf_rd;
          tx_data  <= {3'b101, rf_ra};
          tx_valid <= 1'b1;
          idx      <= '0;
        end
      end
      if (hs) begin
        if (last_byte) begin
          tx_valid <= 1'b0;
          cnt      <= '0;
          if (last_reg) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            rf_ra <= rf_ra + AW'(1);
          end
        end else begin
          tx_data <= next_byte;
          idx     <= idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_debug_rf_reader.sv
// Scoreboard bench for debug_rf_reader: directed stimulus pushes expected bytes,
// a negedge monitor pops and compares on every byte handshake.
module tb_debug_rf_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        single;
  logic [4:0]  sel_addr;
  logic [4:0]  rf_ra;
  logic [31:0] rf_rd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  debug_rf_reader dut (
    .clk(clk), .rst(rst), .start(start), .single(single), .sel_addr(sel_addr),
    .rf_ra(rf_ra), .rf_rd(rf_rd), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int edges    = 0;
  int t0       = 0;
  int hs_count = 0;
  logic [7:0] exp_q[$];

  logic        noise_en = 1'b0;
  logic        dead_en  = 1'b0;
  logic [31:0] noise    = 32'h0;

  // Register-file model
  always_comb begin
    if (noise_en)                     rf_rd = noise;
    else if (dead_en && rf_ra == 5'd5) rf_rd = 32'hDEADBEEF;
    else                              rf_rd = {27'd0, rf_ra} * 32'h01010101;
  end

  always @(posedge clk) noise <= $urandom();
  always @(posedge clk) edges <= edges + 1;

  logic rst_seen = 1'b0;
  always @(posedge clk) rst_seen <= rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: stall stability and byte scoreboard
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h0;
  always @(negedge clk) begin
    if (prev_stall && !rst_seen) begin
      chk("stall_valid", 32'(tx_valid), 32'd1);
      chk("stall_data", 32'(tx_data), 32'(prev_data));
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
    if (tx_valid && tx_ready && !rst) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_byte: got %h expected none", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("tx_byte", 32'(tx_data), 32'(e));
      end
    end
  end

  task automatic push_reg(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({3'b101, r});
    exp_q.push_back(d[31:24]);
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
  endtask

  // Pulse start for one edge; t0 marks the accepting edge
  task automatic do_start(input logic sgl, input logic [4:0] addr);
    @(posedge clk); #1;
    start = 1'b1; single = sgl; sel_addr = addr;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = edges;
  endtask

  task automatic wait_done(input int budget, output int cyc_n, output logic b);
    cyc_n = -1;
    b = 1'bx;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        cyc_n = edges - t0 + 1;
        b = busy;
        break;
      end
    end
  endtask

  int   cyc_n;
  logic b;
  int   base;
  int   dcount;
  bit   seen;

  initial begin
    rst = 1'b1; start = 1'b1; single = 1'b0; sel_addr = 5'd0; tx_ready = 1'b1;

    // Reset held two cycles with start asserted
    repeat (2) begin
      @(negedge clk);
      chk("rst_rf_ra", 32'(rf_ra), 0);
      chk("rst_tx_valid", 32'(tx_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_valid", 32'(tx_valid), 0);

    // Single read of reg 5
    dead_en = 1'b1;
    push_reg(5'd5, 32'hDEADBEEF);
    do_start(1'b1, 5'd5);
    @(negedge clk);
    chk("single_busy_c1", 32'(busy), 1);
    chk("single_rf_ra_c1", 32'(rf_ra), 5);
    chk("single_valid_c1", 32'(tx_valid), 0);
    @(negedge clk);
    chk("single_hdr_c2", 32'(tx_data), 32'hA5);
    wait_done(20, cyc_n, b);
    chk("single_done_cycle", 32'(cyc_n), 7);
    chk("single_busy_at_done", 32'(b), 0);
    chk("single_rf_ra_end", 32'(rf_ra), 5);
    chk("single_q_empty", 32'(exp_q.size()), 0);
    dead_en = 1'b0;

    // Full sweep 0..31
    base = hs_count;
    for (int r = 0; r < 32; r++) push_reg(5'(r), {27'd0, 5'(r)} * 32'h01010101);
    do_start(1'b0, 5'd17);
    wait_done(400, cyc_n, b);
    chk("sweep_done_cycle", 32'(cyc_n), 193);
    chk("sweep_rf_ra_end", 32'(rf_ra), 31);
    chk("sweep_byte_count", 32'(hs_count - base), 160);
    chk("sweep_q_empty", 32'(exp_q.size()), 0);

    // Backpressure: toggling ready with a 10-cycle stall mid-packet
    base = hs_count;
    push_reg(5'd3, 32'h03030303);
    do_start(1'b1, 5'd3);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      int c;
      @(posedge clk); #1;
      c = edges - t0 + 1;
      if (done) seen = 1'b1;
      if (c >= 4 && c < 14) tx_ready = 1'b0;
      else                  tx_ready = c[0];
    end
    tx_ready = 1'b1;
    chk("bp_done_seen", 32'(seen), 1);
    chk("bp_handshakes", 32'(hs_count - base), 5);

    // Capture isolation: rf_rd randomised after the sample edge
    push_reg(5'd9, 32'h09090909);
    do_start(1'b1, 5'd9);
    @(posedge clk); #1;
    noise_en = 1'b1;
    wait_done(20, cyc_n, b);
    noise_en = 1'b0;
    chk("iso_done_cycle", 32'(cyc_n), 7);
    chk("iso_q_empty", 32'(exp_q.size()), 0);

    // Abort: reset right after byte 2 of reg 4 in a sweep
    base = hs_count;
    for (int r = 0; r < 4; r++) push_reg(5'(r), {27'd0, 5'(r)} * 32'h01010101);
    exp_q.push_back(8'hA4);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h04);
    do_start(1'b0, 5'd0);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (hs_count - base >= 23) break;
    end
    chk("abort_reached", 32'(hs_count - base), 23);
    rst = 1'b1; tx_ready = 1'b0;
    @(negedge clk);
    chk("abort_pre_valid", 32'(tx_valid), 1);
    @(negedge clk);
    chk("abort_tx_valid", 32'(tx_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rf_ra", 32'(rf_ra), 0);
    chk("abort_tx_data", 32'(tx_data), 0);
    chk("abort_done", 32'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0; tx_ready = 1'b1;
    dcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 0);
    chk("abort_q_empty", 32'(exp_q.size()), 0);

    // Start while busy is ignored
    base = hs_count;
    push_reg(5'd7, 32'h07070707);
    do_start(1'b1, 5'd7);
    @(posedge clk); #1;
    start = 1'b1; single = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(20, cyc_n, b);
    chk("ign_done_cycle", 32'(cyc_n), 7);
    repeat (20) @(negedge clk);
    chk("ign_busy_after", 32'(busy), 0);
    chk("ign_handshakes", 32'(hs_count - base), 5);
    chk("ign_q_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
